sfx_sequencer: RTL and testbench
================================

# sfx_sequencer

Game-event sound sequencer that sits directly upstream of the audio mixer stage. It turns the level-type `jumping` and `kill` game signals into short multi-note square-wave effects. It presents one signed 32-bit sample per codec request, and the mixer adds that sample to both DAC channels. All note pitches and durations live in an internal ROM, so the mixer carries no tone logic.

## Interface
- `TICK_DIV`, default 50000: CLOCK_50 cycles per duration tick (1 ms at 50 MHz).
- `AMPLITUDE`, default 10000000: peak magnitude of the square wave.
- `GAP_TICKS`, default 10: silent ticks between consecutive notes of one effect.
- `CLOCK_50`, in, 1: system clock; all logic on rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `jumping`, in, 1: jump level from game FSM; a rising edge triggers the jump effect.
- `kill`, in, 1: death level from game FSM; a rising edge triggers the kill effect.
- `mute`, in, 1: forces the sample to 0; sequencing continues.
- `sample_req`, in, 1: one-cycle strobe (audio_in_available & audio_out_allowed) asking for the next sample.
- `sample`, out, 32: signed two's-complement sample, held between requests.
- `busy`, out, 1: high while an effect is in progress.
- `active_sfx`, out, 2: 00 none, 01 jump, 10 kill.

## Operation
- Rising-edge detect on `jumping` and `kill` uses one registered copy of each input; the edge is the input high while the copy is low.
- Note ROM entries are {half_period[18:0], dur_ticks[9:0]}:
  - jump: {19113, 60}, {14317, 60}
  - kill: {6327, 80}, {9479, 80}, {12655, 160}
- FSM states:
  - IDLE: on a kill edge go to LOAD with kill; else on a jump edge go to LOAD with jump.
  - LOAD: latch note[idx], clear tone counter, square bit (=1), tick prescaler and duration counter; go to PLAY.
  - PLAY: tone counter counts 0..half_period, then wraps to 0 and toggles the square bit. On the last tick of dur_ticks, go to GAP if more notes remain, else to IDLE.
  - GAP: level 0 for GAP_TICKS ticks, then idx+1 and go to LOAD.
- Priority and retriggering:
  - Kill edge in any non-IDLE state while playing jump: abort and go to LOAD with kill, idx=0.
  - Jump edge while busy: ignored.
  - Kill edge while playing kill: restarts kill at idx=0.
  - Simultaneous kill and jump edges: kill wins.
- Level:
  - PLAY: +amp when the square bit is 1, −amp when it is 0.
  - Every other state: 0.
  - When `mute`=1: 0.
- `sample` register loads the level only on cycles where `sample_req`=1.
- `busy` = state≠IDLE. `active_sfx` is registered alongside the state.

## Timing
- Reset values: `sample`=0, `busy`=0, `active_sfx`=00, state=IDLE, idx=0, all counters 0, edge registers 0.
- Event latency:
  - Input rises at edge N; LOAD at N+1; PLAY at N+2.
  - `busy` and `active_sfx` are valid from N+1.
- Square-wave timing:
  - First toggle occurs half_period+1 cycles after entering PLAY.
  - Period = 2·(half_period+1) cycles.
- Note length:
  - A note occupies exactly dur_ticks·TICK_DIV cycles in PLAY.
  - A gap occupies exactly GAP_TICKS·TICK_DIV cycles.
  - One cycle of LOAD precedes each note.
- Sample latency: `sample` updates one cycle after a `sample_req` strobe.
- Reset asserted mid-effect: immediate return to reset values, with no completion of the note.
- Width rules:
  - Tone counter is 19 bits; duration counter is 10 bits; prescaler is ⌈log2 TICK_DIV⌉ bits.
  - −amp is the 32-bit two's complement of amp.

## Configuration
- `SFX_DECAY_EN`:
  - Defined: amp = AMPLITUDE >>> idx, so note 0 plays at full level, note 1 at half and note 2 at quarter.
  - Undefined: amp = AMPLITUDE for every note, and the shifter is not built.

## Test plan
- Reset and idle (bench TICK_DIV=100): reset, then pulse `sample_req`:
  - `sample`=0, `busy`=0, `active_sfx`=00 throughout.
- Jump effect: raise `jumping` and hold it high:
  - `active_sfx`=01 from N+1.
  - Samples alternate ±10000000 with a 38228-cycle period.
  - `busy` stays high for 2+6000+1000+1+6000 cycles, then drops.
  - Holding `jumping` high does not retrigger the effect.
- Kill preemption: raise `kill` 3000 cycles into a jump:
  - `active_sfx`=10 two cycles later.
  - Toggle period is 12656.
  - Three notes play, and the sequence ends after 32000 PLAY cycles plus 2000 gap cycles.
- Simultaneous edges: raise `jumping` and `kill` on the same edge:
  - The kill sequence plays and the jump edge is dropped.
- Mute and reset mid-note:
  - `mute`=1 during PLAY: `sample`=0 while `busy` stays 1.
  - Assert `reset` mid-note: all outputs are 0 asynchronously.
- `SFX_DECAY_EN` defined, kill effect:
  - Note magnitudes are 10000000, 5000000 and 2500000.

Source files
------------

// File: rtl/sfx_sequencer.sv
// Game-event square-wave sound sequencer feeding the audio mixer.
// Optional per-note amplitude decay is enabled by defining SFX_DECAY_EN.
module sfx_sequencer #(
    parameter int TICK_DIV  = 50000,
    parameter int AMPLITUDE = 10000000,
    parameter int GAP_TICKS = 10
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        jumping,
    input  logic        kill,
    input  logic        mute,
    input  logic        sample_req,
    output logic [31:0] sample,
    output logic        busy,
    output logic [1:0]  active_sfx
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam logic [1:0] SFX_NONE = 2'b00;
    localparam logic [1:0] SFX_JUMP = 2'b01;
    localparam logic [1:0] SFX_KILL = 2'b10;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]      PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [9:0]         GAP_LAST   = 10'(GAP_TICKS - 1);
    localparam logic signed [31:0] AMP_FULL   = 32'(AMPLITUDE);

    logic [1:0]    state_q, state_d;
    logic [1:0]    sfx_q, sfx_d;
    logic [1:0]    idx_q, idx_d;
    logic [18:0]   half_q, half_d;
    logic [9:0]    dur_q, dur_d;
    logic [18:0]   tone_q, tone_d;
    logic          sq_q, sq_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [9:0]    cnt_q, cnt_d;
    logic          jump_q, kill_q;
    logic [31:0]   sample_q;

    logic jump_edge, kill_edge, tick;
    logic signed [31:0] amp;
    logic [31:0]   level;

    function automatic logic [28:0] note_rom(input logic [1:0] sfx, input logic [1:0] idx);
        case ({sfx, idx})
            4'b01_00: note_rom = {19'd19113, 10'd60};
            4'b01_01: note_rom = {19'd14317, 10'd60};
            4'b10_00: note_rom = {19'd6327,  10'd80};
            4'b10_01: note_rom = {19'd9479,  10'd80};
            4'b10_10: note_rom = {19'd12655, 10'd160};
            default:  note_rom = 29'd0;
        endcase
    endfunction

    function automatic logic is_last_note(input logic [1:0] sfx, input logic [1:0] idx);
        is_last_note = (sfx == SFX_KILL) ? (idx == 2'd2) : (idx == 2'd1);
    endfunction

    assign jump_edge = jumping & ~jump_q;
    assign kill_edge = kill & ~kill_q;
    assign tick      = (presc_q == PRESC_LAST);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d = state_q;
        sfx_d   = sfx_q;
        idx_d   = idx_q;
        half_d  = half_q;
        dur_d   = dur_q;
        tone_d  = tone_q;
        sq_d    = sq_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (kill_edge) begin
                    state_d = ST_LOAD;
                    sfx_d   = SFX_KILL;
                    idx_d   = 2'd0;
                end else if (jump_edge) begin
                    state_d = ST_LOAD;
                    sfx_d   = SFX_JUMP;
                    idx_d   = 2'd0;
                end
            end
            ST_LOAD: begin
                {half_d, dur_d} = note_rom(sfx_q, idx_q);
                tone_d  = 19'd0;
                sq_d    = 1'b1;
                presc_d = '0;
                cnt_d   = 10'd0;
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (tone_q == half_q) begin
                    tone_d = 19'd0;
                    sq_d   = ~sq_q;
                end else begin
                    tone_d = tone_q + 19'd1;
                end
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    if (cnt_q == dur_q - 10'd1) begin
                        cnt_d = 10'd0;
                        if (is_last_note(sfx_q, idx_q)) begin
                            state_d = ST_IDLE;
                            sfx_d   = SFX_NONE;
                            idx_d   = 2'd0;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            ST_GAP: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = 10'd0;
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A kill edge outranks anything in flight, including a kill already playing.
        if (kill_edge && state_q != ST_IDLE) begin
            state_d = ST_LOAD;
            sfx_d   = SFX_KILL;
            idx_d   = 2'd0;
        end
    end

`ifdef SFX_DECAY_EN
    assign amp = AMP_FULL >>> idx_q;
`else
    assign amp = AMP_FULL;
`endif

    always_comb begin
        level = 32'd0;
        if (state_q == ST_PLAY && !mute) begin
            level = sq_q ? amp : -amp;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sfx_q    <= SFX_NONE;
            idx_q    <= 2'd0;
            half_q   <= 19'd0;
            dur_q    <= 10'd0;
            tone_q   <= 19'd0;
            sq_q     <= 1'b0;
            presc_q  <= '0;
            cnt_q    <= 10'd0;
            jump_q   <= 1'b0;
            kill_q   <= 1'b0;
            sample_q <= 32'd0;
        end else begin
            state_q <= state_d;
            sfx_q   <= sfx_d;
            idx_q   <= idx_d;
            half_q  <= half_d;
            dur_q   <= dur_d;
            tone_q  <= tone_d;
            sq_q    <= sq_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            jump_q  <= jumping;
            kill_q  <= kill;
            if (sample_req) begin
                sample_q <= level;
            end
        end
    end

    assign sample     = sample_q;
    assign busy       = (state_q != ST_IDLE);
    assign active_sfx = sfx_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed self-checking bench for sfx_sequencer with a 100-cycle duration tick.
// Expected note amplitudes follow SFX_DECAY_EN when the bench is built with it.
module tb_sfx_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        jumping;
    logic        kill;
    logic        mute;
    logic        sample_req;
    logic [31:0] sample;
    logic        busy;
    logic [1:0]  active_sfx;

    int checks = 0;
    int failures = 0;

    sfx_sequencer #(
        .TICK_DIV  (100),
        .AMPLITUDE (10000000),
        .GAP_TICKS (10)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .jumping    (jumping),
        .kill       (kill),
        .mute       (mute),
        .sample_req (sample_req),
        .sample     (sample),
        .busy       (busy),
        .active_sfx (active_sfx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] amp_of(input int idx);
`ifdef SFX_DECAY_EN
        amp_of = 32'(10000000 >> idx);
`else
        amp_of = 32'd10000000;
`endif
    endfunction

    initial begin
        reset = 1'b1; jumping = 1'b0; kill = 1'b0; mute = 1'b0; sample_req = 1'b0;

        // Reset and idle
        step(3);
        sample_req = 1'b1;
        step(1);
        check("rst_sample", sample, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_active", {30'd0, active_sfx}, 32'd0);
        reset = 1'b0;
        step(5);
        check("idle_sample", sample, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Jump effect: raised just after edge N
        jumping = 1'b1;
        step(1);                                          // N+1
        check("jump_active_n1", {30'd0, active_sfx}, 32'd1);
        check("jump_busy_n1", {31'd0, busy}, 32'd1);
        step(2);                                          // N+3
        check("jump_n0_high", sample, amp_of(0));
        step(5999);                                       // N+6002
        check("jump_n0_last", sample, amp_of(0));
        step(1);                                          // N+6003
        check("jump_gap_zero", sample, 32'd0);
        step(1001);                                       // N+7004
        check("jump_n1_high", sample, amp_of(1));
        step(5998);                                       // N+13002
        check("jump_busy_end", {31'd0, busy}, 32'd1);
        step(1);                                          // N+13003
        check("jump_busy_drop", {31'd0, busy}, 32'd0);
        check("jump_active_drop", {30'd0, active_sfx}, 32'd0);
        step(200);
        check("jump_no_retrig", {31'd0, busy}, 32'd0);

        // Kill preempting a jump 3000 cycles in
        jumping = 1'b0;
        step(3);
        jumping = 1'b1;
        step(3000);
        kill = 1'b1;                                      // K
        step(1);
        check("kill_load_active", {30'd0, active_sfx}, 32'd2);
        step(1);                                          // K+2
        check("kill_active_k2", {30'd0, active_sfx}, 32'd2);
        check("kill_busy_k2", {31'd0, busy}, 32'd1);
        step(6328);                                       // K+6330
        check("kill_n0_pretoggle", sample, amp_of(0));
        step(1);                                          // K+6331
        check("kill_n0_toggle", sample, -amp_of(0));
        step(2673);                                       // K+9004
        check("kill_n1_amp", sample, amp_of(1));
        step(9001);                                       // K+18005
        check("kill_n2_amp", sample, amp_of(2));
        step(12655);                                      // K+30660
        check("kill_n2_pretoggle", sample, amp_of(2));
        step(1);                                          // K+30661
        check("kill_n2_toggle", sample, -amp_of(2));
        step(3342);                                       // K+34003
        check("kill_busy_end", {31'd0, busy}, 32'd1);
        step(1);                                          // K+34004
        check("kill_busy_drop", {31'd0, busy}, 32'd0);
        check("kill_active_drop", {30'd0, active_sfx}, 32'd0);

        // Simultaneous edges: kill wins
        jumping = 1'b0; kill = 1'b0;
        step(5);
        jumping = 1'b1; kill = 1'b1;                      // S
        step(1);
        check("simul_active", {30'd0, active_sfx}, 32'd2);
        step(2);                                          // S+3
        check("simul_sample", sample, amp_of(0));
        step(8001);                                       // S+8004
        check("simul_gap_active", {30'd0, active_sfx}, 32'd2);
        check("simul_gap_sample", sample, 32'd0);

        // Mute during PLAY of kill note 1, then request gating
        step(1006);                                       // S+9010
        check("pre_mute_sample", sample, amp_of(1));
        mute = 1'b1;
        step(2);
        check("mute_sample", sample, 32'd0);
        check("mute_busy", {31'd0, busy}, 32'd1);
        mute = 1'b0; sample_req = 1'b0;
        step(3);
        check("held_sample", sample, 32'd0);
        sample_req = 1'b1;
        step(1);
        check("req_sample", sample, amp_of(1));

        // Asynchronous reset mid-note
        #2;
        reset = 1'b1;
        #1;
        check("arst_sample", sample, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_active", {30'd0, active_sfx}, 32'd0);
        jumping = 1'b0; kill = 1'b0;
        step(3);
        reset = 1'b0;
        step(10);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_sample", sample, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
